// File: rtl/row_sprite_scheduler_pkg.sv
// Shared types and defaults for the per-scanline sprite scheduler.
// Layer fields are sized by the package widths; top-level overrides must match them.
package sprite_pkg;

  localparam int V_TOTAL_D    = 525;
  localparam int V_ACTIVE_D   = 480;
  localparam int ROW_W        = 10;
  localparam int LAYER_ADDR_W = 18;
  localparam int LAYER_DIM_W  = 8;

  typedef struct packed {
    logic                    en;
    logic [ROW_W-1:0]        x;
    logic [ROW_W-1:0]        y;
    logic [LAYER_DIM_W-1:0]  w;
    logic [LAYER_DIM_W-1:0]  h;
    logic [LAYER_ADDR_W-1:0] base;
  } layer_t;

  // Bits needed to hold values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/row_sprite_scheduler_hit_eval.sv
// One-layer row test: hit when the row lies inside [y, y+h) and inside the visible area,
// plus the ROM address of that sprite row (base + row offset * pitch).
module row_hit_eval import sprite_pkg::*; #(
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int ADDR_W   = LAYER_ADDR_W,
  parameter int DIM_W    = LAYER_DIM_W
) (
  input  logic              en_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [ROW_W-1:0]  y_i,
  input  logic [DIM_W-1:0]  w_i,
  input  logic [DIM_W-1:0]  h_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int EW = ROW_W + 1;
  localparam int PW = ROW_W + DIM_W;

  logic [EW-1:0]    end_row;
  logic [ROW_W-1:0] off;
  logic [PW-1:0]    prod;

  // One extra bit so y+h can never wrap back into range.
  assign end_row = EW'(y_i) + EW'(h_i);
  assign hit_o   = en_i && (row_i >= y_i) && (EW'(row_i) < end_row) &&
                   (row_i < ROW_W'(V_ACTIVE));

  assign off    = row_i - y_i;
  assign prod   = PW'(off) * PW'(w_i);
  assign addr_o = base_i + ADDR_W'(prod);

endmodule

// File: rtl/row_sprite_scheduler.sv
// Row-rate sprite scheduler: row counter, ping-pong select, per-frame layer shadows,
// priority-limited per-row hit list with ROM row addresses for the pixel writer.
module row_sprite_scheduler import sprite_pkg::*; #(
  parameter int NUM_LAYERS   = 4,
  parameter int MAX_PER_LINE = 3,
  parameter int V_TOTAL      = V_TOTAL_D,
  parameter int V_ACTIVE     = V_ACTIVE_D,
  parameter int ADDR_W       = LAYER_ADDR_W,
  parameter int DIM_W        = LAYER_DIM_W,
  parameter int CNT_W        = clog2(NUM_LAYERS + 1)
) (
  input  logic                                row_Clk,
  input  logic                                Reset,
  input  logic [NUM_LAYERS-1:0]               layer_en,
  input  logic [NUM_LAYERS-1:0][ROW_W-1:0]    layer_x,
  input  logic [NUM_LAYERS-1:0][ROW_W-1:0]    layer_y,
  input  logic [NUM_LAYERS-1:0][DIM_W-1:0]    layer_w,
  input  logic [NUM_LAYERS-1:0][DIM_W-1:0]    layer_h,
  input  logic [NUM_LAYERS-1:0][ADDR_W-1:0]   layer_base,
  output logic [ROW_W-1:0]                    write_row,
  output logic                                buffer_select,
  output logic                                frame_start,
  output logic                                in_vblank,
  output logic [NUM_LAYERS-1:0]               line_active,
  output logic [NUM_LAYERS-1:0][ADDR_W-1:0]   line_addr,
  output logic [NUM_LAYERS-1:0][ROW_W-1:0]    line_x,
  output logic [CNT_W-1:0]                    active_count,
  output logic                                overflow
);

  logic [ROW_W-1:0]                  row_q, nr;
  logic                              wrap;
  logic                              bsel_q, fs_q, vb_q, ovf_q;
  layer_t [NUM_LAYERS-1:0]           live, sh_q, sh_d;
  logic [NUM_LAYERS-1:0]             hit, keep, act_q;
  logic [NUM_LAYERS-1:0][ADDR_W-1:0] ev_addr, addr_d, addr_q;
  logic [NUM_LAYERS-1:0][ROW_W-1:0]  x_q;
  logic [CNT_W-1:0]                  hit_cnt, kept_cnt, cnt_q;
  logic                              over;

  assign nr   = (row_q == ROW_W'(V_TOTAL - 1)) ? '0 : row_q + ROW_W'(1);
  assign wrap = (nr == '0);

  // Shadows reload on the wrap edge and that same edge already evaluates the new values.
  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      live[k].en   = layer_en[k];
      live[k].x    = layer_x[k];
      live[k].y    = layer_y[k];
      live[k].w    = layer_w[k];
      live[k].h    = layer_h[k];
      live[k].base = layer_base[k];
    end
    sh_d = wrap ? live : sh_q;
  end

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_eval
    row_hit_eval #(
      .V_ACTIVE (V_ACTIVE),
      .ADDR_W   (ADDR_W),
      .DIM_W    (DIM_W)
    ) u_eval (
      .en_i   (sh_d[k].en),
      .row_i  (nr),
      .y_i    (sh_d[k].y),
      .w_i    (sh_d[k].w),
      .h_i    (sh_d[k].h),
      .base_i (sh_d[k].base),
      .hit_o  (hit[k]),
      .addr_o (ev_addr[k])
    );
  end

  // Lowest index wins; hits beyond the per-row budget are dropped but still counted.
  always_comb begin
    keep     = '0;
    hit_cnt  = '0;
    kept_cnt = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (hit[k]) begin
        hit_cnt = hit_cnt + CNT_W'(1);
        if (int'(kept_cnt) < MAX_PER_LINE) begin
          keep[k]  = 1'b1;
          kept_cnt = kept_cnt + CNT_W'(1);
        end
      end
    end
    for (int k = 0; k < NUM_LAYERS; k++)
      addr_d[k] = keep[k] ? ev_addr[k] : '0;
  end

  assign over = (int'(hit_cnt) > MAX_PER_LINE);

  always_ff @(posedge row_Clk or posedge Reset) begin
    if (Reset) begin
      row_q  <= '0;
      bsel_q <= 1'b0;
      fs_q   <= 1'b0;
      vb_q   <= 1'b0;
      ovf_q  <= 1'b0;
      sh_q   <= '0;
      act_q  <= '0;
      addr_q <= '0;
      x_q    <= '0;
      cnt_q  <= '0;
    end else begin
      row_q  <= nr;
      bsel_q <= ~bsel_q;
      fs_q   <= wrap;
      vb_q   <= (nr >= ROW_W'(V_ACTIVE));
      ovf_q  <= wrap ? over : (ovf_q | over);
      sh_q   <= sh_d;
      act_q  <= keep;
      addr_q <= addr_d;
      cnt_q  <= kept_cnt;
      for (int k = 0; k < NUM_LAYERS; k++)
        x_q[k] <= sh_d[k].x;
    end
  end

  assign write_row     = row_q;
  assign buffer_select = bsel_q;
  assign frame_start   = fs_q;
  assign in_vblank     = vb_q;
  assign overflow      = ovf_q;
  assign line_active   = act_q;
  assign line_addr     = addr_q;
  assign line_x        = x_q;
  assign active_count  = cnt_q;

endmodule
